// File: rtl/ex_dispatch_ctrl.sv
// Dispatch gate in front of ID/EX: per-unit RS credits, wrapping tags,
// registered issue strobe, and a drain state after a pipeline flush.
module ex_dispatch_ctrl #(
  parameter int NUM_UNITS = 4,
  parameter int RS_DEPTH  = 4,
  parameter int TAG_W     = 4,
  localparam int UW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1,
  localparam int CW = $clog2(RS_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [UW-1:0]        id_unit,
  output logic                 id_ready,
  input  logic                 id_flush,
  input  logic [NUM_UNITS-1:0] rs_release,
  input  logic                 tag_retire,
  output logic                 issue_valid,
  output logic [UW-1:0]        issue_unit,
  output logic [TAG_W-1:0]     issue_tag,
  output logic [NUM_UNITS-1:0] unit_full,
  output logic                 err
);

  typedef enum logic {RUN, DRAIN} state_e;

  localparam logic [CW-1:0]  FULL    = CW'(RS_DEPTH);
  localparam logic [UW:0]    NU      = (UW+1)'(NUM_UNITS);
  localparam logic [TAG_W:0] MAX_OUT = {1'b1, {TAG_W{1'b0}}};

  state_e               state_q, state_d;
  logic [CW-1:0]        credit_q [NUM_UNITS];
  logic [CW-1:0]        credit_d [NUM_UNITS];
  logic [TAG_W-1:0]     next_tag_q, next_tag_d;
  logic [TAG_W:0]       outstanding_q, outstanding_d;
  logic                 issue_valid_q, issue_valid_d;
  logic [UW-1:0]        issue_unit_q, issue_unit_d;
  logic [TAG_W-1:0]     issue_tag_q, issue_tag_d;
  logic [NUM_UNITS-1:0] unit_full_q, unit_full_d;
  logic                 err_q, err_d;

  logic          unit_ok;
  logic [CW-1:0] sel_credit;
  logic          hs;
  logic          all_full;
  logic          ret_eff;
  logic          dec;

  assign unit_ok = {1'b0, id_unit} < NU;

  // Guarded select so an out-of-range unit never indexes the array
  always_comb begin
    sel_credit = '0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      if (id_unit == UW'(u)) sel_credit = credit_q[u];
    end
  end

  assign id_ready = (state_q == RUN) && unit_ok &&
                    (sel_credit != '0) &&
                    (outstanding_q != MAX_OUT) &&
                    !id_flush && rst;

  assign hs      = id_valid && id_ready;
  assign ret_eff = tag_retire && !id_flush;
  assign dec     = ret_eff && (outstanding_q != '0);

  always_comb begin
    state_d       = state_q;
    next_tag_d    = next_tag_q;
    outstanding_d = outstanding_q;
    issue_valid_d = hs;
    issue_unit_d  = issue_unit_q;
    issue_tag_d   = issue_tag_q;
    unit_full_d   = '0;
    err_d         = err_q;
    all_full      = 1'b1;

    for (int u = 0; u < NUM_UNITS; u++) begin
      logic hs_u;
      hs_u = hs && (id_unit == UW'(u));
      all_full = all_full && (credit_q[u] == FULL);
      credit_d[u] = credit_q[u];
      if (rs_release[u] && !hs_u && credit_q[u] == FULL) err_d = 1'b1;
      if (hs_u && !rs_release[u]) begin
        credit_d[u] = credit_q[u] - CW'(1);
      end else if (rs_release[u] && !hs_u && credit_q[u] != FULL) begin
        credit_d[u] = credit_q[u] + CW'(1);
      end
      unit_full_d[u] = (credit_d[u] == '0);
    end

    if (id_valid && !unit_ok) err_d = 1'b1;
    if (ret_eff && outstanding_q == '0) err_d = 1'b1;

    if (id_flush) begin
      outstanding_d = '0;
    end else if (hs && !dec) begin
      outstanding_d = outstanding_q + 1'b1;
    end else if (!hs && dec) begin
      outstanding_d = outstanding_q - 1'b1;
    end

    if (hs) begin
      next_tag_d   = next_tag_q + 1'b1;
      issue_unit_d = id_unit;
      issue_tag_d  = next_tag_q;
    end

    unique case (state_q)
      RUN:   if (id_flush) state_d = DRAIN;
      DRAIN: if (!id_flush && all_full) state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= RUN;
      next_tag_q    <= '0;
      outstanding_q <= '0;
      issue_valid_q <= 1'b0;
      issue_unit_q  <= '0;
      issue_tag_q   <= '0;
      unit_full_q   <= '0;
      err_q         <= 1'b0;
      for (int u = 0; u < NUM_UNITS; u++) credit_q[u] <= FULL;
    end else begin
      state_q       <= state_d;
      next_tag_q    <= next_tag_d;
      outstanding_q <= outstanding_d;
      issue_valid_q <= issue_valid_d;
      issue_unit_q  <= issue_unit_d;
      issue_tag_q   <= issue_tag_d;
      unit_full_q   <= unit_full_d;
      err_q         <= err_d;
      for (int u = 0; u < NUM_UNITS; u++) credit_q[u] <= credit_d[u];
    end
  end

  assign issue_valid = issue_valid_q;
  assign issue_unit  = issue_unit_q;
  assign issue_tag   = issue_tag_q;
  assign unit_full   = unit_full_q;
  assign err         = err_q;

endmodule

// File: tb/tb_ex_dispatch_ctrl.sv
// Randomized bench for ex_dispatch_ctrl against a cycle-level
// reference model of credits, tags and the flush drain.
module tb_ex_dispatch_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       id_valid = 1'b0;
  logic [1:0] id_unit = '0;
  logic       id_ready;
  logic       id_flush = 1'b0;
  logic [3:0] rs_release = '0;
  logic       tag_retire = 1'b0;
  logic       issue_valid;
  logic [1:0] issue_unit;
  logic [3:0] issue_tag;
  logic [3:0] unit_full;
  logic       err;

  int checks = 0;
  int errors = 0;

  int credit [4];
  int next_tag, outstanding;
  bit drain, m_err;
  bit exp_iv;
  int exp_iu, exp_it;

  ex_dispatch_ctrl dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_unit(id_unit), .id_ready(id_ready),
    .id_flush(id_flush), .rs_release(rs_release),
    .tag_retire(tag_retire), .issue_valid(issue_valid),
    .issue_unit(issue_unit), .issue_tag(issue_tag),
    .unit_full(unit_full), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int u = 0; u < 4; u++) credit[u] = 4;
    next_tag = 0; outstanding = 0;
    drain = 0; m_err = 0;
    exp_iv = 0; exp_iu = 0; exp_it = 0;
  endtask

  task automatic check_regs();
    check("issue_valid", issue_valid, exp_iv);
    if (exp_iv) begin
      check("issue_unit", issue_unit, exp_iu);
      check("issue_tag", issue_tag, exp_it);
    end
    for (int u = 0; u < 4; u++)
      check($sformatf("unit_full%0d", u), unit_full[u], credit[u] == 0);
    check("err", err, m_err);
  endtask

  function automatic logic [3:0] avail_mask();
    logic [3:0] m;
    for (int u = 0; u < 4; u++) m[u] = credit[u] < 4;
    return m;
  endfunction

  // Called at a negedge: drive, check ready, advance model, check regs
  task automatic step(input bit v, input int unit, input bit fl,
                      input logic [3:0] rel, input bit ret);
    bit exp_ready, hs, all_full, h;
    id_valid = v; id_unit = 2'(unit); id_flush = fl;
    rs_release = rel; tag_retire = ret;
    #1;
    exp_ready = !drain && credit[unit] > 0 && outstanding < 16 && !fl;
    check("id_ready", id_ready, exp_ready);
    hs = v && exp_ready;
    @(posedge clk);
    all_full = 1;
    for (int u = 0; u < 4; u++) if (credit[u] != 4) all_full = 0;
    for (int u = 0; u < 4; u++) begin
      h = hs && unit == u;
      if (h && rel[u]) begin
      end else if (rel[u]) begin
        if (credit[u] == 4) m_err = 1;
        else credit[u]++;
      end else if (h) begin
        credit[u]--;
      end
    end
    if (fl) outstanding = 0;
    else begin
      if (ret && outstanding == 0) m_err = 1;
      outstanding = outstanding + (hs ? 1 : 0) -
                    ((ret && outstanding > 0) ? 1 : 0);
    end
    exp_iv = hs;
    if (hs) begin
      exp_iu = unit; exp_it = next_tag;
      next_tag = (next_tag + 1) % 16;
    end
    if (fl) drain = 1;
    else if (drain && all_full) drain = 0;
    @(negedge clk);
    #1;
    check_regs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    id_valid = 0; id_flush = 0; rs_release = '0; tag_retire = 0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  initial begin
    model_reset();
    id_valid = 1'b1; id_unit = 2'd2;
    #2;
    check("rst_id_ready", id_ready, 0);
    check("rst_issue_valid", issue_valid, 0);
    check("rst_issue_unit", issue_unit, 0);
    check("rst_issue_tag", issue_tag, 0);
    check("rst_unit_full", unit_full, 0);
    check("rst_err", err, 0);
    do_reset();

    // Fill unit 2: four accepts then stall
    for (int i = 0; i < 5; i++) step(1, 2, 0, 4'b0000, 0);
    check("fill_full2", unit_full[2], 1);

    // Unit 1 starved then one release
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 1, 0, 4'b0000, 0);
    step(1, 1, 0, 4'b0010, 0);
    step(1, 1, 0, 4'b0000, 0);
    check("starve_tag", issue_tag, 4);

    // Same-cycle accept and release on unit 0, tags wrap
    do_reset();
    for (int i = 0; i < 20; i++) step(1, 0, 0, 4'b0001, i >= 4);
    check("wrap_full0", unit_full[0], 0);
    check("wrap_err", err, 0);

    // Tag exhaustion at 16 outstanding
    do_reset();
    for (int i = 0; i < 19; i++) step(1, i % 4, 0, avail_mask(), 0);
    step(1, 0, 0, avail_mask(), 1);
    step(1, 1, 0, avail_mask(), 0);
    check("exh_tag", issue_tag, 0);
    step(1, 2, 0, avail_mask(), 0);

    // Flush with three entries in unit 3
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 3, 0, 4'b0000, 0);
    step(1, 3, 1, 4'b0000, 0);
    for (int i = 0; i < 3; i++) step(1, 3, 0, 4'b0000, 0);
    for (int i = 0; i < 3; i++) step(1, 3, 0, 4'b1000, 0);
    for (int i = 0; i < 3; i++) step(1, 3, 0, 4'b0000, 0);

    // Protocol errors are sticky
    do_reset();
    step(0, 0, 0, 4'b0001, 0);
    step(0, 0, 0, 4'b0000, 1);
    for (int i = 0; i < 3; i++) step(1, i, 0, 4'b0000, 0);

    // Asynchronous reset mid-burst
    id_valid = 1; id_unit = 2'd3;
    #2 rst = 1'b0;
    #1;
    check("mid_issue_valid", issue_valid, 0);
    check("mid_id_ready", id_ready, 0);
    check("mid_unit_full", unit_full, 0);
    check("mid_err", err, 0);
    check("mid_issue_tag", issue_tag, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      bit v, fl, ret;
      int un;
      logic [3:0] rel;
      v   = ($urandom % 4) != 0;
      un  = $urandom % 4;
      fl  = ($urandom % 50) == 0;
      rel = 4'($urandom) & avail_mask();
      ret = outstanding > 0 && ($urandom % 3) == 0;
      if (($urandom % 400) == 0) rel = 4'($urandom);
      step(v, un, fl, rel, ret);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
